num_matrix_loader: RTL and testbench

//  Downstream stage of the ASCII number separator. On separator completion it reads the parsed-number RAM.

---
 rtl/num_matrix_loader_if.sv | 25 ++
 rtl/num_matrix_loader.sv | 165 ++++++++++++++++
 tb/tb_num_matrix_loader.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/num_matrix_loader_if.sv
// Element write port between the matrix loader and matrix storage.
// The loader holds valid, addr and data steady until storage raises ready.
interface num_matrix_loader_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int EADDR_WIDTH = 5
);
    logic                   mat_wr_valid;
    logic                   mat_wr_ready;
    logic [EADDR_WIDTH-1:0] mat_wr_addr;
    logic [DATA_WIDTH-1:0]  mat_wr_data;

    modport master (
        output mat_wr_valid,
        output mat_wr_addr,
        output mat_wr_data,
        input  mat_wr_ready
    );

    modport slave (
        input  mat_wr_valid,
        input  mat_wr_addr,
        input  mat_wr_data,
        output mat_wr_ready
    );
endinterface

// File: rtl/num_matrix_loader.sv
// Reads rows, cols and elements from the separator RAM into matrix storage.
// LOADER_ZERO_FILL_EN: a short element count is padded with zero writes.
module num_matrix_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int MAX_DIM     = 5,
    parameter int EADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sep_done,
    input  logic                  sep_invalid,
    input  logic [ADDR_WIDTH-1:0] sep_num_count,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    num_matrix_loader_if.master   mat,
    output logic [2:0]            mat_rows,
    output logic [2:0]            mat_cols,
    output logic                  busy,
    output logic                  load_done,
    output logic                  load_error,
    output logic [1:0]            err_code
);

    typedef enum logic [3:0] {
        IDLE, CHK_SEP, RD_ROWS, RD_COLS, DIMCHK,
        RD_ELEM, WR_ELEM, DONE, ERR
    } state_t;

    localparam logic signed [DATA_WIDTH-1:0] DIM_LO = DATA_WIDTH'(1);
    localparam logic signed [DATA_WIDTH-1:0] DIM_HI = DATA_WIDTH'(MAX_DIM);

    state_t                 state;
    logic                   sep_q;
    logic                   rows_ok;
    logic [ADDR_WIDTH-1:0]  navail;
    logic [EADDR_WIDTH-1:0] total;
    logic [EADDR_WIDTH-1:0] idx;

    logic                   trigger;
    logic                   dim_ok;
    logic                   count_bad;
    logic [EADDR_WIDTH-1:0] prod;
    logic [EADDR_WIDTH-1:0] idx_nx;

    assign trigger = sep_done & ~sep_q;
    assign dim_ok  = ($signed(rd_data) >= DIM_LO) &&
                     ($signed(rd_data) <= DIM_HI);
    assign prod    = EADDR_WIDTH'(mat_rows) * EADDR_WIDTH'(rd_data[2:0]);
    assign idx_nx  = idx + EADDR_WIDTH'(1);

`ifdef LOADER_ZERO_FILL_EN
    assign count_bad = navail > ADDR_WIDTH'(prod);
`else
    assign count_bad = navail != ADDR_WIDTH'(prod);
`endif

    // Tracking sep_done through reset keeps a held level from retriggering.
    always_ff @(posedge clk) begin
        sep_q <= sep_done;
        if (rst) begin
            state            <= IDLE;
            rows_ok          <= 1'b0;
            navail           <= '0;
            total            <= '0;
            idx              <= '0;
            rd_addr          <= '0;
            mat.mat_wr_valid <= 1'b0;
            mat.mat_wr_addr  <= '0;
            mat.mat_wr_data  <= '0;
            mat_rows         <= '0;
            mat_cols         <= '0;
            busy             <= 1'b0;
            load_done        <= 1'b0;
            load_error       <= 1'b0;
            err_code         <= 2'd0;
        end else begin
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (trigger) begin
                        state      <= CHK_SEP;
                        busy       <= 1'b1;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                        err_code   <= 2'd0;
                    end
                end
                CHK_SEP: begin
                    navail <= sep_num_count - ADDR_WIDTH'(2);
                    idx    <= '0;
                    if (sep_invalid) begin
                        state      <= ERR;
                        busy       <= 1'b0;
                        load_done  <= 1'b1;
                        load_error <= 1'b1;
                        err_code   <= 2'd1;
                    end else if (sep_num_count < ADDR_WIDTH'(2)) begin
                        state      <= ERR;
                        busy       <= 1'b0;
                        load_done  <= 1'b1;
                        load_error <= 1'b1;
                        err_code   <= 2'd2;
                    end else begin
                        rd_addr <= '0;
                        state   <= RD_ROWS;
                    end
                end
                RD_ROWS: begin
                    rd_addr <= ADDR_WIDTH'(1);
                    state   <= RD_COLS;
                end
                RD_COLS: begin
                    mat_rows <= rd_data[2:0];
                    rows_ok  <= dim_ok;
                    // Issue the first element read now so it lands in RD_ELEM.
                    rd_addr  <= ADDR_WIDTH'(2);
                    state    <= DIMCHK;
                end
                DIMCHK: begin
                    mat_cols <= rd_data[2:0];
                    total    <= prod;
                    if (!rows_ok || !dim_ok) begin
                        state      <= ERR;
                        busy       <= 1'b0;
                        load_done  <= 1'b1;
                        load_error <= 1'b1;
                        err_code   <= 2'd2;
                    end else if (count_bad) begin
                        state      <= ERR;
                        busy       <= 1'b0;
                        load_done  <= 1'b1;
                        load_error <= 1'b1;
                        err_code   <= 2'd3;
                    end else begin
                        state <= RD_ELEM;
                    end
                end
                RD_ELEM: begin
                    mat.mat_wr_addr  <= idx;
                    mat.mat_wr_data  <= (ADDR_WIDTH'(idx) < navail) ?
                                        rd_data : '0;
                    mat.mat_wr_valid <= 1'b1;
                    // Prefetch the next word while the write handshake runs.
                    rd_addr          <= rd_addr + ADDR_WIDTH'(1);
                    state            <= WR_ELEM;
                end
                WR_ELEM: begin
                    if (mat.mat_wr_ready) begin
                        mat.mat_wr_valid <= 1'b0;
                        idx              <= idx_nx;
                        if (idx_nx == total) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state <= RD_ELEM;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_num_matrix_loader.sv
// Directed bench for num_matrix_loader with a synchronous RAM model
// and a write-port monitor that records accepted writes.
module tb_num_matrix_loader;

    logic        clk;
    logic        rst;
    logic        sep_done;
    logic        sep_invalid;
    logic [10:0] sep_num_count;
    logic [10:0] rd_addr;
    logic [31:0] rd_data;
    logic [2:0]  mat_rows;
    logic [2:0]  mat_cols;
    logic        busy;
    logic        load_done;
    logic        load_error;
    logic [1:0]  err_code;

    num_matrix_loader_if #(.DATA_WIDTH(32), .EADDR_WIDTH(5)) mif ();

    num_matrix_loader dut (
        .clk           (clk),
        .rst           (rst),
        .sep_done      (sep_done),
        .sep_invalid   (sep_invalid),
        .sep_num_count (sep_num_count),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .mat           (mif),
        .mat_rows      (mat_rows),
        .mat_cols      (mat_cols),
        .busy          (busy),
        .load_done     (load_done),
        .load_error    (load_error),
        .err_code      (err_code)
    );

    int vectors;
    int miscompares;

    logic [31:0] ram [0:2047];
    logic [4:0]  wa [$];
    logic [31:0] wd [$];
    int          stab_err;
    int          valid_cyc;
    int          ready_mode;
    int          rcyc;
    logic        pend;
    logic [4:0]  p_addr;
    logic [31:0] p_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= ram[rd_addr];

    initial begin
        mif.mat_wr_ready = 1'b1;
        rcyc = 0;
        forever begin
            @(posedge clk);
            #2;
            rcyc++;
            mif.mat_wr_ready = (ready_mode == 0) ? 1'b1 : (rcyc % 3 == 0);
        end
    end

    // Mid-cycle view: valid&&ready here means acceptance at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend && (!mif.mat_wr_valid || mif.mat_wr_addr !== p_addr ||
                         mif.mat_wr_data !== p_data))
                stab_err++;
            if (mif.mat_wr_valid) valid_cyc++;
            if (mif.mat_wr_valid && mif.mat_wr_ready) begin
                wa.push_back(mif.mat_wr_addr);
                wd.push_back(mif.mat_wr_data);
            end
            pend   = mif.mat_wr_valid && !mif.mat_wr_ready;
            p_addr = mif.mat_wr_addr;
            p_data = mif.mat_wr_data;
        end
    end

    task automatic clear_ram();
        for (int i = 0; i < 64; i++) ram[i] = 32'd0;
    endtask

    task automatic start_load(input int cnt, input bit inv, output bit to);
        int c;
        c = cnt;
        @(negedge clk);
        sep_done      = 1'b0;
        sep_num_count = c[10:0];
        sep_invalid   = inv;
        @(negedge clk);
        wa.delete();
        wd.delete();
        stab_err = 0;
        sep_done = 1'b1;
        @(negedge clk);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (load_done) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, load_done, load_error, err_code} !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, load_done, load_error, err_code});
        end
        vectors++;
        if ({mat_rows, mat_cols, rd_addr} !== 17'd0) begin
            miscompares++;
            $display("FAIL reset_regs: got %h expected 0",
                     {mat_rows, mat_cols, rd_addr});
        end
        vectors++;
        if (mif.mat_wr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b expected 0", mif.mat_wr_valid);
        end
    endtask

    task automatic test_basic(input int mode);
        int ed[4] = '{1, -2, 3, 4};
        bit to;
        clear_ram();
        ram[0] = 2; ram[1] = 2; ram[2] = 1;
        ram[3] = -2; ram[4] = 3; ram[5] = 4;
        ready_mode = mode;
        start_load(6, 1'b0, to);
        vectors++;
        if (to !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_timeout: got %b expected 0", to);
        end
        vectors++;
        if (wa.size() !== 4) begin
            miscompares++;
            $display("FAIL basic_count: got %0d expected 4", wa.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                vectors++;
                if (wa[i] !== 5'(i) || wd[i] !== 32'(ed[i])) begin
                    miscompares++;
                    $display("FAIL basic_write%0d: got %0d:%0d expected %0d:%0d",
                             i, wa[i], $signed(wd[i]), i, ed[i]);
                end
            end
        end
        vectors++;
        if ({mat_rows, mat_cols} !== 6'o22) begin
            miscompares++;
            $display("FAIL basic_dims: got %0d,%0d expected 2,2",
                     mat_rows, mat_cols);
        end
        vectors++;
        if ({busy, load_done, load_error, err_code} !== 5'b01000) begin
            miscompares++;
            $display("FAIL basic_status: got %b expected 01000",
                     {busy, load_done, load_error, err_code});
        end
        vectors++;
        if (stab_err !== 0) begin
            miscompares++;
            $display("FAIL basic_stable: got %0d expected 0", stab_err);
        end
        ready_mode = 0;
    endtask

    task automatic test_error(input int cnt, input bit inv,
                              input logic [1:0] code);
        bit to;
        start_load(cnt, inv, to);
        vectors++;
        if (to !== 1'b0) begin
            miscompares++;
            $display("FAIL err_timeout: got %b expected 0", to);
        end
        vectors++;
        if ({busy, load_done, load_error, err_code} !== {3'b011, code}) begin
            miscompares++;
            $display("FAIL err_status: got %b expected %b",
                     {busy, load_done, load_error, err_code},
                     {3'b011, code});
        end
        vectors++;
        if (wa.size() !== 0) begin
            miscompares++;
            $display("FAIL err_writes: got %0d expected 0", wa.size());
        end
    endtask

    task automatic test_bad_dims();
        clear_ram();
        ram[0] = 6; ram[1] = 2;
        test_error(14, 1'b0, 2'd2);
        clear_ram();
        ram[0] = -1; ram[1] = 3;
        test_error(2, 1'b0, 2'd2);
        clear_ram();
        ram[0] = 2; ram[1] = 0;
        test_error(2, 1'b0, 2'd2);
        test_error(1, 1'b0, 2'd2);
    endtask

    task automatic test_invalid();
        clear_ram();
        ram[0] = 1; ram[1] = 1; ram[2] = 9;
        test_error(3, 1'b1, 2'd1);
    endtask

    task automatic test_count_mismatch();
        clear_ram();
        ram[0] = 2; ram[1] = 2;
        test_error(7, 1'b0, 2'd3);
    endtask

    task automatic test_short_count();
        bit to;
        int ed[6] = '{1, 2, 3, 0, 0, 0};
        clear_ram();
        ram[0] = 2; ram[1] = 3; ram[2] = 1; ram[3] = 2; ram[4] = 3;
        ram[5] = 77; ram[6] = 88; ram[7] = 99;
`ifdef LOADER_ZERO_FILL_EN
        start_load(5, 1'b0, to);
        vectors++;
        if (to !== 1'b0 || {load_error, err_code} !== 3'd0 ||
            wa.size() !== 6) begin
            miscompares++;
            $display("FAIL fill_status: got to=%b err=%b n=%0d expected 0 000 6",
                     to, {load_error, err_code}, wa.size());
        end
        for (int i = 0; i < 6; i++) begin
            if (i < wa.size()) begin
                vectors++;
                if (wa[i] !== 5'(i) || wd[i] !== 32'(ed[i])) begin
                    miscompares++;
                    $display("FAIL fill_write%0d: got %0d:%0d expected %0d:%0d",
                             i, wa[i], $signed(wd[i]), i, ed[i]);
                end
            end
        end
`else
        to = ed[0] == 1;
        test_error(5, 1'b0, 2'd3);
`endif
    endtask

    task automatic test_single();
        bit to;
        clear_ram();
        ram[0] = 1; ram[1] = 1; ram[2] = -7; ram[3] = 5;
        start_load(3, 1'b0, to);
        vectors++;
        if (to !== 1'b0 || wa.size() !== 1 || load_error !== 1'b0) begin
            miscompares++;
            $display("FAIL single_count: got to=%b n=%0d err=%b expected 0 1 0",
                     to, wa.size(), load_error);
        end
        if (wa.size() > 0) begin
            vectors++;
            if (wa[0] !== 5'd0 || wd[0] !== 32'hFFFF_FFF9) begin
                miscompares++;
                $display("FAIL single_write: got %0d:%0d expected 0:-7",
                         wa[0], $signed(wd[0]));
            end
        end
    endtask

    task automatic test_max_dims();
        bit to;
        int bad;
        clear_ram();
        ram[0] = 5; ram[1] = 5;
        for (int i = 0; i < 25; i++) ram[2+i] = 32'(i * 7 - 30);
        start_load(27, 1'b0, to);
        vectors++;
        if (to !== 1'b0 || wa.size() !== 25 || load_error !== 1'b0) begin
            miscompares++;
            $display("FAIL max_count: got to=%b n=%0d err=%b expected 0 25 0",
                     to, wa.size(), load_error);
        end
        bad = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] !== 5'(i) || wd[i] !== 32'(i * 7 - 30)) bad++;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL max_writes: got %0d bad expected 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_ram();
        ram[0] = 2; ram[1] = 2; ram[2] = 1;
        ram[3] = -2; ram[4] = 3; ram[5] = 4;
        @(negedge clk);
        sep_done = 1'b0;
        sep_num_count = 11'd6;
        sep_invalid = 1'b0;
        @(negedge clk);
        wa.delete();
        wd.delete();
        sep_done = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wa.size() >= 2) begin
                to = 1'b0;
                break;
            end
        end
        vectors++;
        if (to !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_wait: got %b expected 0", to);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({busy, load_done, load_error, err_code, mif.mat_wr_valid,
             mat_rows, mat_cols, rd_addr} !== 23'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %h expected 0",
                     {busy, load_done, load_error, err_code, mif.mat_wr_valid,
                      mat_rows, mat_cols, rd_addr});
        end
        @(negedge clk);
        rst = 1'b0;
        valid_cyc = 0;
        repeat (20) @(negedge clk);
        vectors++;
        if (valid_cyc !== 0 || wa.size() !== 2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_quiet: got v=%0d n=%0d busy=%b expected 0 2 0",
                     valid_cyc, wa.size(), busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        stab_err    = 0;
        valid_cyc   = 0;
        ready_mode  = 0;
        pend        = 1'b0;
        rst         = 1'b1;
        sep_done    = 1'b0;
        sep_invalid = 1'b0;
        sep_num_count = 11'd0;
        for (int i = 0; i < 2048; i++) ram[i] = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic(0);
        test_basic(1);
        test_bad_dims();
        test_invalid();
        test_count_mismatch();
        test_short_count();
        test_single();
        test_max_dims();
        test_reset_mid();
        test_basic(0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
